// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC update logic: PC-source codes,
// FSM state encoding and the default datapath width.
package pc_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_TRAP
  } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target generation for branch and jalr, plus misaligned-target detection.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      i_prePCSrc,
  input  logic [XLEN-1:0] i_pcE,
  input  logic [XLEN-1:0] i_immE,
  input  logic [XLEN-1:0] i_rs1E,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  always_comb begin
    // Bit1 selects the jalr path, so the illegal code 11 also behaves as jalr.
    if ((i_prePCSrc & PCSRC_JALR) != 2'b00) begin
      target = (i_rs1E + i_immE) & ~XLEN'(1);
    end else begin
      target = i_pcE + i_immE;
    end
    misaligned = (i_prePCSrc != PCSRC_SEQ) && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_update_unit.sv
// Fetch program counter owner: next-PC selection, fetch handshake,
// redirect flush and instruction-address-misaligned trap.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_prePCSrc,
  input  logic [XLEN-1:0] i_pcE,
  input  logic [XLEN-1:0] i_immE,
  input  logic [XLEN-1:0] i_rs1E,
  input  logic            i_stall,
  input  logic            i_imemReady,
  output logic            o_imemValid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcPlus4,
  output logic            o_flush,
  output logic            o_excMisaligned,
  output logic [XLEN-1:0] o_excTval
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            redirect;

  if ((RESET_PC[1:0] != 2'b00) || (TRAP_VEC[1:0] != 2'b00)) begin : g_align_chk
    $error("pc_update_unit: RESET_PC and TRAP_VEC must be 4-byte aligned");
  end

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .i_prePCSrc (i_prePCSrc),
    .i_pcE      (i_pcE),
    .i_immE     (i_immE),
    .i_rs1E     (i_rs1E),
    .target     (target),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    tval_d          = tval_q;
    redirect        = 1'b0;
    o_imemValid     = 1'b0;
    o_excMisaligned = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        o_imemValid = 1'b1;
        redirect    = (i_prePCSrc != PCSRC_SEQ);
        // A redirect abandons the outstanding fetch, so it beats stall and ignores ready.
        if (redirect && misaligned) begin
          pc_d    = TRAP_VEC;
          tval_d  = target;
          state_d = S_TRAP;
        end else if (redirect) begin
          pc_d = target;
        end else if (!i_stall && i_imemReady) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      S_TRAP: begin
        o_excMisaligned = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

  assign o_flush   = redirect;
  assign o_pc      = pc_q;
  assign o_pcPlus4 = pc_q + XLEN'(4);
  assign o_excTval = tval_q;

  // Code 11 is never produced by a correct decoder.
  a_no_code11 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == S_FETCH) |-> (i_prePCSrc != 2'b11));

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed sequences, a vector table
// and a randomized run against a behavioural model.
module tb_pc_update_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        i_clk;
  logic        i_rst_n;
  logic [1:0]  i_prePCSrc;
  logic [31:0] i_pcE, i_immE, i_rs1E;
  logic        i_stall, i_imemReady;
  logic        o_imemValid;
  logic [31:0] o_pc, o_pcPlus4;
  logic        o_flush, o_excMisaligned;
  logic [31:0] o_excTval;

  int checks = 0;
  int errors = 0;

  pc_update_unit dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_prePCSrc      (i_prePCSrc),
    .i_pcE           (i_pcE),
    .i_immE          (i_immE),
    .i_rs1E          (i_rs1E),
    .i_stall         (i_stall),
    .i_imemReady     (i_imemReady),
    .o_imemValid     (o_imemValid),
    .o_pc            (o_pc),
    .o_pcPlus4       (o_pcPlus4),
    .o_flush         (o_flush),
    .o_excMisaligned (o_excMisaligned),
    .o_excTval       (o_excTval)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [1:0]  src;
    logic [31:0] pc_e;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;
    logic        exp_exc;
    logic [31:0] exp_tval;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pc"},    o_pc, RESET_PC);
    chk({tag, " valid"}, 32'(o_imemValid), 32'd0);
    chk({tag, " flush"}, 32'(o_flush), 32'd0);
    chk({tag, " exc"},   32'(o_excMisaligned), 32'd0);
    chk({tag, " tval"},  o_excTval, 32'd0);
  endtask

  // Behavioural model state for the randomized phase.
  logic [31:0] m_pc, m_tval, n_pc, n_tval, tgt;
  logic        m_boot, m_trap, n_boot, n_trap, m_fetching;

  initial begin
    vecs[0] = '{2'b01, 32'h0000_1000, 32'h0000_0010, 32'h0,         32'h0000_1010, 1'b0, 32'h0};
    vecs[1] = '{2'b10, 32'h0,         32'h0,         32'h0000_2001, 32'h0000_2000, 1'b0, 32'h0};
    vecs[2] = '{2'b01, 32'h0000_1000, 32'h0000_0002, 32'h0,         TRAP_VEC,      1'b1, 32'h0000_1002};
    vecs[3] = '{2'b10, 32'h0,         32'hFFFF_FFFF, 32'h0000_3000, TRAP_VEC,      1'b1, 32'h0000_2FFE};
    vecs[4] = '{2'b01, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         32'h0000_0010, 1'b0, 32'h0};
    vecs[5] = '{2'b10, 32'h0,         32'hFFFF_FFFC, 32'h0000_0007, TRAP_VEC,      1'b1, 32'h0000_0002};

    // Reset and boot sequence
    i_rst_n = 1'b0; i_prePCSrc = 2'b00; i_pcE = '0; i_immE = '0; i_rs1E = '0;
    i_stall = 1'b0; i_imemReady = 1'b1;
    #3;
    chk_reset_outputs("reset");
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("boot valid", 32'(o_imemValid), 32'd0);
    tick();
    chk("fetch valid", 32'(o_imemValid), 32'd1);
    chk("seq pc0", o_pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq pc", o_pc, 32'(4 * i));
    end
    tick();
    chk("seq pc 0x10", o_pc, 32'h10);

    // Stall holds the PC
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall hold", o_pc, 32'h10);
    end
    i_stall = 1'b0;
    tick();
    chk("stall release", o_pc, 32'h14);

    // Branch redirect overrides stall
    i_prePCSrc = 2'b01; i_pcE = 32'h20; i_immE = 32'hFFFF_FFF0; i_stall = 1'b1;
    #1;
    chk("br flush", 32'(o_flush), 32'd1);
    tick();
    chk("br over stall", o_pc, 32'h10);
    i_stall = 1'b0;

    // jalr with bit0 masking
    i_prePCSrc = 2'b10; i_rs1E = 32'h101; i_immE = 32'h3;
    #1;
    chk("jalr flush", 32'(o_flush), 32'd1);
    tick();
    chk("jalr pc", o_pc, 32'h104);
    chk("jalr no exc", 32'(o_excMisaligned), 32'd0);

    // Misaligned jalr target traps
    i_rs1E = 32'h100; i_immE = 32'h2;
    #1;
    chk("mis flush", 32'(o_flush), 32'd1);
    tick();
    i_prePCSrc = 2'b01; i_pcE = 32'h4000; i_immE = 32'h8;
    #1;
    chk("trap exc", 32'(o_excMisaligned), 32'd1);
    chk("trap valid", 32'(o_imemValid), 32'd0);
    chk("trap tval", o_excTval, 32'h102);
    chk("trap pc", o_pc, TRAP_VEC);
    chk("trap no flush", 32'(o_flush), 32'd0);
    tick();
    i_prePCSrc = 2'b00;
    #1;
    chk("resume valid", 32'(o_imemValid), 32'd1);
    chk("resume exc", 32'(o_excMisaligned), 32'd0);
    chk("resume pc", o_pc, TRAP_VEC);
    chk("tval held", o_excTval, 32'h102);

    // Vector table of redirects
    for (int v = 0; v < 6; v++) begin
      i_prePCSrc = vecs[v].src; i_pcE = vecs[v].pc_e; i_immE = vecs[v].imm; i_rs1E = vecs[v].rs1;
      #1;
      chk($sformatf("vec%0d flush", v), 32'(o_flush), 32'd1);
      tick();
      i_prePCSrc = 2'b00;
      chk($sformatf("vec%0d pc", v), o_pc, vecs[v].exp_pc);
      chk($sformatf("vec%0d exc", v), 32'(o_excMisaligned), 32'(vecs[v].exp_exc));
      if (vecs[v].exp_exc) begin
        chk($sformatf("vec%0d tval", v), o_excTval, vecs[v].exp_tval);
        tick();
        chk($sformatf("vec%0d resume", v), o_pc, TRAP_VEC);
      end
    end

    // PC wrap, then asynchronous reset mid-cycle
    i_prePCSrc = 2'b01; i_pcE = 32'hFFFF_FFF0; i_immE = 32'hC;
    tick();
    i_prePCSrc = 2'b00;
    chk("wrap pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap plus4", o_pcPlus4, 32'h0);
    tick();
    chk("wrap to 0", o_pc, 32'h0);
    chk("wrap no exc", 32'(o_excMisaligned), 32'd0);
    tick();
    i_prePCSrc = 2'b01; i_pcE = 32'h800; i_immE = 32'h40;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    tick();
    i_rst_n = 1'b1;

    // Randomized run against the behavioural model
    m_pc = RESET_PC; m_tval = '0; m_boot = 1'b1; m_trap = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      i_prePCSrc  = (r < 6) ? 2'b00 : ((r < 8) ? 2'b01 : 2'b10);
      i_pcE       = $urandom & 32'hFFFF_FFFC;
      i_immE      = $urandom;
      if ($urandom_range(0, 1) == 0) i_immE[1:0] = 2'b00;
      i_rs1E      = $urandom;
      i_stall     = ($urandom_range(0, 3) == 0);
      i_imemReady = ($urandom_range(0, 3) != 0);
      #1;
      m_fetching = !m_boot && !m_trap;
      chk("rnd valid", 32'(o_imemValid), 32'(m_fetching));
      chk("rnd flush", 32'(o_flush), 32'(m_fetching && (i_prePCSrc != 2'b00)));
      chk("rnd exc", 32'(o_excMisaligned), 32'(m_trap));
      chk("rnd pc", o_pc, m_pc);
      chk("rnd plus4", o_pcPlus4, m_pc + 32'd4);
      chk("rnd tval", o_excTval, m_tval);

      n_pc = m_pc; n_tval = m_tval; n_boot = 1'b0; n_trap = 1'b0;
      if (m_fetching) begin
        if (i_prePCSrc == 2'b01) tgt = i_pcE + i_immE;
        else                     tgt = ((i_rs1E + i_immE) / 2) * 2;
        if (i_prePCSrc != 2'b00) begin
          if (tgt % 4 != 0) begin
            n_pc = TRAP_VEC; n_tval = tgt; n_trap = 1'b1;
          end else begin
            n_pc = tgt;
          end
        end else if (!i_stall && i_imemReady) begin
          n_pc = m_pc + 32'd4;
        end
      end
      tick();
      m_pc = n_pc; m_tval = n_tval; m_boot = n_boot; m_trap = n_trap;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
